// File: rtl/anemo_gen_pkg.sv
// Shared constants and types for the anemometer pulse generator.
//   - register addresses, CTRL/STATUS bit positions, minimum half-period
//   - waveform FSM state enum and the STATUS register layout
package anemo_gen_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_HP     = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_BURST  = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_BURST_BIT = 1;
    localparam int unsigned CTRL_CLR_BIT   = 2;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_DONE_BIT = 1;
    localparam int unsigned STAT_CNT_LSB  = 16;

    localparam int unsigned HP_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } wave_state_e;

    typedef struct packed {
        logic [15:0] edge_count;
        logic [13:0] rsvd;
        logic        done;
        logic        busy;
    } status_t;

endpackage

// File: rtl/anemo_pulse_gen_if.sv
// Avalon-MM slave bus bundle for the pulse generator.
//   chipselect, address, write_n, writedata, read_n : master -> slave
//   readdata                                        : slave -> master (latency 1)
interface anemo_pulse_gen_if;
    import anemo_gen_pkg::*;

    logic              chipselect;
    logic [ADDR_W-1:0] address;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic              read_n;
    logic [DATA_W-1:0] readdata;

    modport master (
        output chipselect, address, write_n, writedata, read_n,
        input  readdata
    );

    modport slave (
        input  chipselect, address, write_n, writedata, read_n,
        output readdata
    );

endinterface

// File: rtl/anemo_wave_core.sv
// Waveform engine: IDLE/HIGH/LOW/DONE FSM, half-period counter,
// burst edge counter and free-running rising-edge counter.
//   in : clk, reset_n, en, burst, half_period, burst_len, clr
//   out: wave_out (high only in HIGH), busy, done, edge_count
module anemo_wave_core
    import anemo_gen_pkg::*;
#(
    parameter int unsigned HP_WIDTH  = 24,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 burst,
    input  logic [HP_WIDTH-1:0]  half_period,
    input  logic [CNT_WIDTH-1:0] burst_len,
    input  logic                 clr,
    output logic                 wave_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] edge_count
);

    wave_state_e          state_q;
    wave_state_e          state_nxt;
    logic [HP_WIDTH-1:0]  hp_cnt;
    logic [HP_WIDTH-1:0]  hp_cur;
    logic [HP_WIDTH-1:0]  hp_eff;
    logic [CNT_WIDTH-1:0] burst_cnt;
    logic                 phase_end;
    logic                 state_chg;
    logic                 rise;
    logic                 wave_d;
    logic                 busy_d;
    logic                 done_d;

    // Post-reset HALF_PERIOD is 0; never run a phase shorter than HP_MIN.
    assign hp_eff    = (half_period < HP_WIDTH'(HP_MIN)) ? HP_WIDTH'(HP_MIN) : half_period;
    // hp_cur is the value latched at the last state change, so a new
    // HALF_PERIOD never disturbs the phase in progress.
    assign phase_end = (hp_cnt == hp_cur - HP_WIDTH'(1));
    assign state_chg = (state_nxt != state_q);
    assign rise      = (state_nxt == ST_HIGH) && (state_q != ST_HIGH);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; EN=0 overrides every state.
    always_comb begin
        state_nxt = state_q;
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (burst && (burst_len == CNT_WIDTH'(0))) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        state_nxt = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (phase_end) begin
                        if (burst && (burst_cnt == burst_len)) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_HIGH;
                        end
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_DONE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state, registered below.
    always_comb begin
        wave_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (state_nxt)
            ST_HIGH: begin
                wave_d = 1'b1;
                busy_d = 1'b1;
            end
            ST_LOW:  busy_d = 1'b1;
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wave_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            wave_out <= wave_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Phase timer and edge counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hp_cnt     <= '0;
            hp_cur     <= '0;
            burst_cnt  <= '0;
            edge_count <= '0;
        end else begin
            if (state_chg) begin
                hp_cnt <= '0;
                hp_cur <= hp_eff;
            end else if ((state_q == ST_HIGH) || (state_q == ST_LOW)) begin
                hp_cnt <= hp_cnt + HP_WIDTH'(1);
            end

            if (state_nxt == ST_IDLE) begin
                burst_cnt <= '0;
            end else if (rise) begin
                burst_cnt <= burst_cnt + CNT_WIDTH'(1);
            end

            // CLR beats a coincident rising edge.
            if (clr) begin
                edge_count <= '0;
            end else if (rise) begin
                edge_count <= edge_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/anemo_pulse_gen.sv
// Avalon-MM register file for the anemometer sensor emulator.
//   clk, reset_n : clock, async active-low reset
//   avs          : Avalon slave (CTRL, HALF_PERIOD, BURST_LEN, STATUS)
//   anemo_out    : generated square wave
module anemo_pulse_gen
    import anemo_gen_pkg::*;
#(
    parameter int unsigned HP_WIDTH  = 24,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    anemo_pulse_gen_if.slave   avs,
    output logic               anemo_out
);

    logic                 wr_c;
    logic                 rd_c;
    logic                 clr_c;
    logic                 ctrl_en;
    logic                 ctrl_burst;
    logic [HP_WIDTH-1:0]  half_period;
    logic [CNT_WIDTH-1:0] burst_len;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] edge_count;
    logic [DATA_W-1:0]    rd_mux;
    logic                 unused_wdata;

    assign wr_c  = avs.chipselect & ~avs.write_n;
    assign rd_c  = avs.chipselect & ~avs.read_n;
    // CLR is a write-side strobe only; it is never stored.
    assign clr_c = wr_c && (avs.address == ADDR_CTRL) && avs.writedata[CTRL_CLR_BIT];
    assign unused_wdata = ^avs.writedata;

    // Register writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_burst  <= 1'b0;
            half_period <= '0;
            burst_len   <= '0;
        end else if (wr_c) begin
            unique case (avs.address)
                ADDR_CTRL: begin
                    ctrl_en    <= avs.writedata[CTRL_EN_BIT];
                    ctrl_burst <= avs.writedata[CTRL_BURST_BIT];
                end
                ADDR_HP: begin
                    half_period <= (avs.writedata[HP_WIDTH-1:0] < HP_WIDTH'(HP_MIN))
                                   ? HP_WIDTH'(HP_MIN) : avs.writedata[HP_WIDTH-1:0];
                end
                ADDR_BURST: burst_len <= avs.writedata[CNT_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Read mux.
    always_comb begin
        status_t st;
        rd_mux = '0;
        st     = '0;
        unique case (avs.address)
            ADDR_CTRL: begin
                rd_mux[CTRL_EN_BIT]    = ctrl_en;
                rd_mux[CTRL_BURST_BIT] = ctrl_burst;
            end
            ADDR_HP:    rd_mux = DATA_W'(half_period);
            ADDR_BURST: rd_mux = DATA_W'(burst_len);
            ADDR_STATUS: begin
                st.edge_count = 16'(edge_count);
                st.done       = done;
                st.busy       = busy;
                rd_mux        = st;
            end
            default: ;
        endcase
    end

    // readdata holds between reads; a same-cycle write is not yet visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs.readdata <= '0;
        end else if (rd_c) begin
            avs.readdata <= rd_mux;
        end
    end

    anemo_wave_core #(
        .HP_WIDTH  (HP_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (ctrl_en),
        .burst       (ctrl_burst),
        .half_period (half_period),
        .burst_len   (burst_len),
        .clr         (clr_c),
        .wave_out    (anemo_out),
        .busy        (busy),
        .done        (done),
        .edge_count  (edge_count)
    );

endmodule
